// File: rtl/parking_gate_arbiter_if.sv
// Handshake bundle between the sensor logic (master) and the gate arbiter (slave).
// Carries the entry/exit requests, the grant pulses and the lot status outputs.
interface parking_gate_arbiter_if #(
    parameter int SLOTS = 4,
    parameter int IDW   = 2
);
    logic             entry_req;
    logic             exit_req;
    logic [IDW-1:0]   exit_slot;
    logic             entry_ack;
    logic [IDW-1:0]   entry_slot;
    logic             entry_reject;
    logic             exit_ack;
    logic             exit_err;
    logic             door_open;
    logic [SLOTS-1:0] occupancy;
    logic [3:0]       free_count;
    logic             full;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_ack, entry_slot, entry_reject, exit_ack, exit_err,
        input  door_open, occupancy, free_count, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_ack, entry_slot, entry_reject, exit_ack, exit_err,
        output door_open, occupancy, free_count, full
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shares the single parking gate between entry and exit requesters, allocates the
// lowest free slot on entry, frees slots on exit and times the door-open window.
module parking_gate_arbiter #(
    parameter int SLOTS       = 4,
    parameter int IDW         = 2,
    parameter int DOOR_CYCLES = 8
) (
    input logic                   clk,
    input logic                   reset,
    parking_gate_arbiter_if.slave bus
);
    localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;
    typedef enum logic {SERVED_ENTRY, SERVED_EXIT} served_t;

    state_t           state_q, state_d;
    served_t          last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [3:0]       free_q, free_d;
    logic             full_q, full_d;
    logic [IDW-1:0]   slot_q, slot_d;
    logic             entry_ack_q, entry_ack_d;
    logic             entry_reject_q, entry_reject_d;
    logic             exit_ack_q, exit_ack_d;
    logic             exit_err_q, exit_err_d;
    logic             entry_armed_q, entry_armed_d;
    logic             exit_armed_q, exit_armed_d;

    logic [IDW-1:0]   free_idx;
    logic             exit_hit;
    logic             entry_elig, exit_elig, serve_exit, serve_entry;

    // Lowest-index free slot, and whether the slot being vacated is really occupied
    always_comb begin
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = IDW'(i);
        end
        exit_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (bus.exit_slot == IDW'(i) && occ_q[i]) exit_hit = 1'b1;
        end
    end

    assign entry_elig  = bus.entry_req && entry_armed_q;
    assign exit_elig   = bus.exit_req && exit_armed_q;
    assign serve_exit  = exit_elig && (!entry_elig || last_q == SERVED_ENTRY);
    assign serve_entry = entry_elig && !serve_exit;

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        occ_d          = occ_q;
        free_d         = free_q;
        slot_d         = slot_q;
        entry_ack_d    = 1'b0;
        entry_reject_d = 1'b0;
        exit_ack_d     = 1'b0;
        exit_err_d     = 1'b0;
        entry_armed_d  = entry_armed_q | ~bus.entry_req;
        exit_armed_d   = exit_armed_q | ~bus.exit_req;

        case (state_q)
            IDLE: begin
                if (serve_exit) begin
                    last_d       = SERVED_EXIT;
                    exit_armed_d = 1'b0;
                    if (exit_hit) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (bus.exit_slot == IDW'(i)) occ_d[i] = 1'b0;
                        end
                        free_d     = free_q + 4'd1;
                        exit_ack_d = 1'b1;
                        state_d    = OPEN;
                        cnt_d      = CW'(DOOR_CYCLES - 1);
                    end else begin
                        exit_err_d = 1'b1;
                    end
                end else if (serve_entry) begin
                    last_d        = SERVED_ENTRY;
                    entry_armed_d = 1'b0;
                    if (!full_q) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (free_idx == IDW'(i)) occ_d[i] = 1'b1;
                        end
                        free_d      = free_q - 4'd1;
                        slot_d      = free_idx;
                        entry_ack_d = 1'b1;
                        state_d     = OPEN;
                        cnt_d       = CW'(DOOR_CYCLES - 1);
                    end else begin
                        entry_reject_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (cnt_q == '0) state_d = CLOSE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        full_d = &occ_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_q         <= SERVED_ENTRY;
            cnt_q          <= '0;
            occ_q          <= '0;
            free_q         <= 4'(SLOTS);
            full_q         <= 1'b0;
            slot_q         <= '0;
            entry_ack_q    <= 1'b0;
            entry_reject_q <= 1'b0;
            exit_ack_q     <= 1'b0;
            exit_err_q     <= 1'b0;
            entry_armed_q  <= 1'b1;
            exit_armed_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            occ_q          <= occ_d;
            free_q         <= free_d;
            full_q         <= full_d;
            slot_q         <= slot_d;
            entry_ack_q    <= entry_ack_d;
            entry_reject_q <= entry_reject_d;
            exit_ack_q     <= exit_ack_d;
            exit_err_q     <= exit_err_d;
            entry_armed_q  <= entry_armed_d;
            exit_armed_q   <= exit_armed_d;
        end
    end

    assign bus.entry_ack    = entry_ack_q;
    assign bus.entry_slot   = slot_q;
    assign bus.entry_reject = entry_reject_q;
    assign bus.exit_ack     = exit_ack_q;
    assign bus.exit_err     = exit_err_q;
    assign bus.door_open    = (state_q == OPEN);
    assign bus.occupancy    = occ_q;
    assign bus.free_count   = free_q;
    assign bus.full         = full_q;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: entry/exit grants, full-lot reject,
// tie-breaking, invalid exits, reset during OPEN and back-to-back alternation.
module tb_parking_gate_arbiter;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parking_gate_arbiter_if #(.SLOTS(4), .IDW(2)) bus ();

    parking_gate_arbiter #(.SLOTS(4), .IDW(2), .DOOR_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) tick();
    endtask

    // Pulse outputs packed as {entry_ack, entry_reject, exit_ack, exit_err}
    function automatic logic [3:0] pulses();
        return {bus.entry_ack, bus.entry_reject, bus.exit_ack, bus.exit_err};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_slot = 2'd0;
        idle_wait(2);
        checks++;
        if ({bus.door_open, bus.occupancy, bus.free_count, bus.full, pulses(), bus.entry_slot} !== {1'b0, 4'b0000, 4'd4, 1'b0, 4'b0000, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_state got door=%b occ=%b free=%0d full=%b pulses=%b slot=%0d, expected 0 0000 4 0 0000 0",
                     bus.door_open, bus.occupancy, bus.free_count, bus.full, pulses(), bus.entry_slot);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.door_open, pulses(), bus.occupancy} !== {1'b0, 4'b0000, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got door=%b pulses=%b occ=%b, expected 0 0000 0000", bus.door_open, pulses(), bus.occupancy);
        end
    endtask

    task automatic test_first_entry();
        bus.entry_req = 1'b1;
        tick();
        checks++;
        if ({pulses(), bus.entry_slot, bus.occupancy, bus.free_count, bus.door_open} !== {4'b1000, 2'd0, 4'b0001, 4'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL first_grant got pulses=%b slot=%0d occ=%b free=%0d door=%b, expected 1000 0 0001 3 1",
                     pulses(), bus.entry_slot, bus.occupancy, bus.free_count, bus.door_open);
        end
        for (int i = 1; i < D; i++) begin
            tick();
            if (i == 2) bus.entry_req = 1'b0;
            checks++;
            if ({pulses(), bus.door_open} !== {4'b0000, 1'b1}) begin
                errors++;
                $display("[TB] FAIL door_open_cycle%0d got pulses=%b door=%b, expected 0000 1", i + 1, pulses(), bus.door_open);
            end
        end
        tick();
        checks++;
        if ({pulses(), bus.door_open} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL door_close_cycle got pulses=%b door=%b, expected 0000 0", pulses(), bus.door_open);
        end
        tick();
        checks++;
        if ({bus.door_open, bus.occupancy, bus.entry_slot} !== {1'b0, 4'b0001, 2'd0}) begin
            errors++;
            $display("[TB] FAIL idle_after_close got door=%b occ=%b slot=%0d, expected 0 0001 0", bus.door_open, bus.occupancy, bus.entry_slot);
        end
    endtask

    task automatic test_fill_and_reject();
        for (int s = 1; s < 4; s++) begin
            bus.entry_req = 1'b1;
            tick();
            bus.entry_req = 1'b0;
            checks++;
            if ({pulses(), bus.entry_slot} !== {4'b1000, 2'(s)}) begin
                errors++;
                $display("[TB] FAIL fill_slot%0d got pulses=%b slot=%0d, expected 1000 %0d", s, pulses(), bus.entry_slot, s);
            end
            idle_wait(D + 1);
        end
        checks++;
        if ({bus.occupancy, bus.free_count, bus.full} !== {4'b1111, 4'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL lot_full got occ=%b free=%0d full=%b, expected 1111 0 1", bus.occupancy, bus.free_count, bus.full);
        end
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        checks++;
        if ({pulses(), bus.door_open, bus.occupancy} !== {4'b0100, 1'b0, 4'b1111}) begin
            errors++;
            $display("[TB] FAIL reject_when_full got pulses=%b door=%b occ=%b, expected 0100 0 1111", pulses(), bus.door_open, bus.occupancy);
        end
        tick();
        checks++;
        if ({pulses(), bus.door_open} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reject_one_cycle got pulses=%b door=%b, expected 0000 0", pulses(), bus.door_open);
        end
    endtask

    task automatic test_tie();
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd2;
        tick();
        bus.exit_req = 1'b0;
        checks++;
        if ({pulses(), bus.occupancy, bus.free_count, bus.full, bus.door_open} !== {4'b0010, 4'b1011, 4'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL tie_exit_first got pulses=%b occ=%b free=%0d full=%b door=%b, expected 0010 1011 1 0 1",
                     pulses(), bus.occupancy, bus.free_count, bus.full, bus.door_open);
        end
        idle_wait(D + 1);
        checks++;
        if ({pulses(), bus.entry_slot, bus.door_open} !== {4'b0000, 2'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL tie_entry_waits got pulses=%b slot=%0d door=%b, expected 0000 3 0", pulses(), bus.entry_slot, bus.door_open);
        end
        tick();
        bus.entry_req = 1'b0;
        checks++;
        if ({pulses(), bus.entry_slot, bus.occupancy, bus.full} !== {4'b1000, 2'd2, 4'b1111, 1'b1}) begin
            errors++;
            $display("[TB] FAIL tie_entry_served got pulses=%b slot=%0d occ=%b full=%b, expected 1000 2 1111 1",
                     pulses(), bus.entry_slot, bus.occupancy, bus.full);
        end
        idle_wait(D + 1);
    endtask

    task automatic test_reset_mid_open();
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd3;
        tick();
        bus.exit_req = 1'b0;
        checks++;
        if ({pulses(), bus.occupancy} !== {4'b0010, 4'b0111}) begin
            errors++;
            $display("[TB] FAIL exit_slot3 got pulses=%b occ=%b, expected 0010 0111", pulses(), bus.occupancy);
        end
        idle_wait(3);
        checks++;
        if (bus.door_open !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_open_door got %b, expected 1", bus.door_open);
        end
        reset = 1'b1;
        bus.entry_req = 1'b1;
        tick();
        checks++;
        if ({bus.door_open, bus.occupancy, bus.free_count, bus.full, pulses(), bus.entry_slot} !== {1'b0, 4'b0000, 4'd4, 1'b0, 4'b0000, 2'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_open got door=%b occ=%b free=%0d full=%b pulses=%b slot=%0d, expected 0 0000 4 0 0000 0",
                     bus.door_open, bus.occupancy, bus.free_count, bus.full, pulses(), bus.entry_slot);
        end
        reset = 1'b0;
        tick();
        bus.entry_req = 1'b0;
        checks++;
        if ({pulses(), bus.entry_slot, bus.occupancy, bus.door_open} !== {4'b1000, 2'd0, 4'b0001, 1'b1}) begin
            errors++;
            $display("[TB] FAIL grant_after_reset got pulses=%b slot=%0d occ=%b door=%b, expected 1000 0 0001 1",
                     pulses(), bus.entry_slot, bus.occupancy, bus.door_open);
        end
        idle_wait(D + 1);
    endtask

    task automatic test_exit_err();
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd1;
        tick();
        bus.exit_req = 1'b0;
        checks++;
        if ({pulses(), bus.door_open, bus.occupancy} !== {4'b0001, 1'b0, 4'b0001}) begin
            errors++;
            $display("[TB] FAIL exit_err_unoccupied got pulses=%b door=%b occ=%b, expected 0001 0 0001", pulses(), bus.door_open, bus.occupancy);
        end
        tick();
        checks++;
        if ({pulses(), bus.door_open} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL exit_err_one_cycle got pulses=%b door=%b, expected 0000 0", pulses(), bus.door_open);
        end
        bus.exit_req  = 1'b1;
        bus.exit_slot = 2'd0;
        tick();
        bus.exit_req = 1'b0;
        checks++;
        if ({pulses(), bus.occupancy, bus.free_count, bus.full, bus.door_open} !== {4'b0010, 4'b0000, 4'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL exit_slot0 got pulses=%b occ=%b free=%0d full=%b door=%b, expected 0010 0000 4 0 1",
                     pulses(), bus.occupancy, bus.free_count, bus.full, bus.door_open);
        end
        idle_wait(D + 1);
    endtask

    // Last serve before this was an exit, so entry wins the opening tie
    task automatic test_back_to_back();
        int grants    = 0;
        int lastCycle = 0;
        int expKind   = 0;
        int kind;
        int expCycle;
        bit sawBad    = 1'b0;
        bus.exit_slot = 2'd0;
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        for (int cyc = 1; cyc <= 60 && grants < 4; cyc++) begin
            tick();
            bus.entry_req = 1'b1;
            bus.exit_req  = 1'b1;
            if (bus.entry_reject || bus.exit_err) sawBad = 1'b1;
            if (bus.entry_ack || bus.exit_ack) begin
                kind     = bus.exit_ack ? 1 : 0;
                expCycle = (grants == 0) ? 1 : lastCycle + D + 2;
                checks++;
                if (kind != expKind || cyc != expCycle) begin
                    errors++;
                    $display("[TB] FAIL b2b_grant%0d got kind=%0d cycle=%0d, expected kind=%0d cycle=%0d", grants, kind, cyc, expKind, expCycle);
                end
                if (kind == 1) bus.exit_req = 1'b0;
                else           bus.entry_req = 1'b0;
                lastCycle = cyc;
                grants++;
                expKind = 1 - expKind;
            end
        end
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        checks++;
        if (grants != 4 || sawBad) begin
            errors++;
            $display("[TB] FAIL b2b_count got grants=%0d bad_pulse=%0b, expected 4 0", grants, sawBad);
        end
        checks++;
        if ({bus.occupancy, bus.free_count} !== {4'b0000, 4'd4}) begin
            errors++;
            $display("[TB] FAIL b2b_final_occ got occ=%b free=%0d, expected 0000 4", bus.occupancy, bus.free_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_entry();
        test_fill_and_reject();
        test_tie();
        test_reset_mid_open();
        test_exit_err();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Arbitrates the parking lot's single shared gate between entry and exit requests. Allocates the lowest-index free slot to each entering car and releases slots on exit. Keeps the occupancy bitmap, free count and full flag, and times the door-open window. It sits between the debounced entry/exit sensor logic and the door, slot-status and capacity display logic.

## Interface
Parameters:
- SLOTS, default 4: number of parking slots (legal range 2..8).
- IDW, default 2: slot index width. Must be at least ceil(log2(SLOTS)).
- DOOR_CYCLES, default 8: cycles door_open stays high per grant (must be ≥1).

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- entry_req  in  1  level request from a car at the entry gate.
- exit_req  in  1  level request from a car leaving.
- exit_slot  in  IDW  slot being vacated. Sampled only in the cycle exit_req is granted.
- entry_ack  out  1  one-cycle pulse: entry granted.
- entry_slot  out  IDW  assigned slot. Valid while entry_ack=1; holds its last value otherwise.
- entry_reject  out  1  one-cycle pulse: entry refused because the lot is full.
- exit_ack  out  1  one-cycle pulse: exit granted.
- exit_err  out  1  one-cycle pulse: exit_slot out of range or not occupied.
- door_open  out  1  gate open.
- occupancy  out  SLOTS  bit i = slot i occupied.
- free_count  out  4  SLOTS minus popcount(occupancy).
- full  out  1  occupancy all ones.

## Operation
- States: IDLE, OPEN, CLOSE.
- Arming: each requester has an armed flag.
  - Reset sets the flag to 1.
  - Ack or reject clears it.
  - Sampling the request low sets it again.
  - A request is eligible only when its req is high and its flag is armed. A held request therefore never produces a second grant or reject.
- IDLE arbitration, at each edge:
  - Only one eligible request: serve it.
  - Both eligible: serve the opposite of last_served.
  - last_served resets to ENTRY, so exit wins the first tie after reset.
  - Any serve updates last_served, including reject and err.
- Entry serve, not full:
  - Set the bit of the lowest-index free slot.
  - entry_slot = that index; pulse entry_ack.
  - State → OPEN, counter = DOOR_CYCLES-1.
- Entry serve, full: pulse entry_reject; stay IDLE; occupancy unchanged.
- Exit serve, exit_slot < SLOTS and bit set:
  - Clear the bit; pulse exit_ack.
  - State → OPEN, counter = DOOR_CYCLES-1.
- Exit serve, invalid slot: pulse exit_err; stay IDLE; occupancy unchanged.
- OPEN: door_open=1. Decrement the counter; at 0 go to CLOSE.
- CLOSE: door_open=0 for one cycle, then IDLE. This gives a guaranteed closed cycle between cars.
- Requests arriving outside IDLE are not lost. They are served at the first IDLE edge if still high and armed.
- full, free_count and occupancy are registered and update in the same cycle as the ack.
- Reset at any time, including mid-OPEN:
  - State → IDLE; door_open=0; occupancy=0; free_count=SLOTS; full=0.
  - All pulses 0; entry_slot=0; both armed=1; last_served=ENTRY.

## Timing
- Request sampled high at edge t in IDLE → ack/reject/err is high in cycle t+1 (one-cycle latency).
- door_open is high in cycles t+1 .. t+DOOR_CYCLES and low in cycle t+DOOR_CYCLES+1 (CLOSE).
- The next grant can be sampled at edge t+DOOR_CYCLES+2 at the earliest.
- Reject and err take one cycle; the next request can be served at edge t+1.
- Every pulse output is exactly one cycle wide and mutually exclusive with the others.
- Requester obligation: deassert req after ack/reject before requesting again.

## Test plan
- Reset, then entry_req high for 3 cycles → single entry_ack one cycle after sampling; entry_slot=0; occupancy=0001; free_count=3; door_open high 8 cycles, then 1 cycle low.
- Four entries, each dropping req after ack → slots 0,1,2,3; full=1. Fifth entry → entry_reject one cycle later; no door_open; occupancy stays 1111.
- occupancy=1111, entry_req and exit_req (exit_slot=2) rise together → exit served first (exit_ack, occupancy=1011). Entry is served at the next IDLE with entry_slot=2.
- Exit with exit_slot=1 while occupancy=0001 → exit_err pulse; no door; occupancy unchanged. Exit with exit_slot=0 → exit_ack; occupancy=0000; free_count=4.
- Reset asserted during OPEN, cycle 4 → next cycle door_open=0, occupancy=0, full=0, state IDLE. entry_req held high through reset → granted on the first edge after reset with slot 0.
- Both requesters held high continuously, dropping req only on their own ack → grants alternate exit, entry, exit… with spacing exactly DOOR_CYCLES+2 cycles.
